// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO. Multiplies finish after MUL_CYCLES busy cycles, divides run
// one restoring shift/subtract step per cycle for DIV_CYCLES cycles on
// operand magnitudes, with the sign fix-up applied on the final step.
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  count_r, count_s;
  logic        op_signed_r, op_signed_s;
  logic [31:0] opa_r, opa_s, opb_r, opb_s;
  logic [31:0] rem_r, rem_s, quo_r, quo_s, dvs_r, dvs_s;
  logic        neg_q_r, neg_q_s, neg_rem_r, neg_rem_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;
  logic        busy_r, busy_s;

  logic [32:0] rem_shift_s, diff_s;
  logic [31:0] step_rem_s, step_quo_s;
  logic [63:0] prod_s;

  // Two's-complement negate when neg is set, otherwise pass through.
  function automatic logic [31:0] cneg(input logic [31:0] v, input logic neg);
    cneg = neg ? (32'd0 - v) : v;
  endfunction

  // One restoring divide step plus the full-width product of the latched operands.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[31]};
    diff_s      = rem_shift_s - {1'b0, dvs_r};
    if (!diff_s[32]) begin
      step_rem_s = diff_s[31:0];
      step_quo_s = {quo_r[30:0], 1'b1};
    end else begin
      step_rem_s = rem_shift_s[31:0];
      step_quo_s = {quo_r[30:0], 1'b0};
    end
    if (op_signed_r) begin
      prod_s = {{32{opa_r[31]}}, opa_r} * {{32{opb_r[31]}}, opb_r};
    end else begin
      prod_s = {32'd0, opa_r} * {32'd0, opb_r};
    end
  end

  // Next-state, operand latching, HI/LO update and busy control.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    op_signed_s = op_signed_r;
    opa_s       = opa_r;
    opb_s       = opb_r;
    rem_s       = rem_r;
    quo_s       = quo_r;
    dvs_s       = dvs_r;
    neg_q_s     = neg_q_r;
    neg_rem_s   = neg_rem_r;
    hi_s        = hi_r;
    lo_s        = lo_r;
    busy_s      = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          // A flush suppresses both a launch and any MTHI/MTLO write.
          busy_s = 1'b0;
        end else if (start) begin
          // Launch wins over a same-cycle MTHI/MTLO write.
          op_signed_s = ~md_op[0];
          opa_s       = src_a;
          opb_s       = src_b;
          rem_s       = 32'd0;
          quo_s       = cneg(src_a, ~md_op[0] & src_a[31]);
          dvs_s       = cneg(src_b, ~md_op[0] & src_b[31]);
          neg_q_s     = ~md_op[0] & (src_a[31] ^ src_b[31]);
          neg_rem_s   = ~md_op[0] & src_a[31];
          busy_s      = 1'b1;
          if (md_op[1]) begin
            state_s = ST_DIV;
            count_s = 5'(DIV_CYCLES - 1);
          end else begin
            state_s = ST_MUL;
            count_s = 5'(MUL_CYCLES - 1);
          end
        end else begin
          if (hi_we) begin
            hi_s = wdata;
          end else begin
            hi_s = hi_r;
          end
          if (lo_we) begin
            lo_s = wdata;
          end else begin
            lo_s = lo_r;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_s = ST_IDLE;
          count_s = 5'd0;
          busy_s  = 1'b0;
        end else if (count_r == 5'd0) begin
          hi_s    = prod_s[63:32];
          lo_s    = prod_s[31:0];
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else begin
          count_s = count_r - 5'd1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_s = ST_IDLE;
          count_s = 5'd0;
          busy_s  = 1'b0;
        end else begin
          rem_s = step_rem_s;
          quo_s = step_quo_s;
          if (count_r == 5'd0) begin
            // Divide by zero yields an all-ones magnitude quotient before sign fix-up.
            hi_s    = cneg(step_rem_s, neg_rem_r);
            lo_s    = cneg(step_quo_s, neg_q_r);
            state_s = ST_IDLE;
            busy_s  = 1'b0;
          end else begin
            count_s = count_r - 5'd1;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = 5'd0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      count_r     <= 5'd0;
      op_signed_r <= 1'b0;
      opa_r       <= 32'd0;
      opb_r       <= 32'd0;
      rem_r       <= 32'd0;
      quo_r       <= 32'd0;
      dvs_r       <= 32'd0;
      neg_q_r     <= 1'b0;
      neg_rem_r   <= 1'b0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      op_signed_r <= op_signed_s;
      opa_r       <= opa_s;
      opb_r       <= opb_s;
      rem_r       <= rem_s;
      quo_r       <= quo_s;
      dvs_r       <= dvs_s;
      neg_q_r     <= neg_q_s;
      neg_rem_r   <= neg_rem_s;
      hi_r        <= hi_s;
      lo_r        <= lo_s;
      busy_r      <= busy_s;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: each launched operation pushes its expected
// busy length and final HI/LO; a monitor pops and checks on each busy fall.
module tb_md_unit;

  localparam int MULC = 5;
  localparam int DIVC = 32;

  logic        clk, reset, start, hi_we, lo_we, flush;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy;
  logic [31:0] hi, lo;

  md_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          mon_run = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi, m_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic rules.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    logic [31:0] ma, mb, q, r;
    logic        sgn;
    case (op)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        return 64'(sp);
      end
      2'd1: begin
        up = 64'(a) * 64'(b);
        return up;
      end
      default: begin
        sgn = (op == 2'd2);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (mb == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = ma;
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
      end
    endcase
  endfunction

  // Monitor: measure each busy run and check it against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      mon_run = 0;
    end else if (busy) begin
      mon_run++;
    end else if (mon_run > 0) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: busy run %0d with no expected entry", mon_run);
      end else begin
        mon_e = sb_q.pop_front();
        chk("busy_len", 64'(mon_run), 64'(mon_e.len));
        chk("res_hi", 64'(hi), 64'(mon_e.hi));
        chk("res_lo", 64'(lo), 64'(mon_e.lo));
      end
      mon_run = 0;
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    exp_t        e;
    r = ref_md(op, a, b);
    e.len = op[1] ? DIVC : MULC;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    sb_q.push_back(e);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = ref_md(op, a, b);
    push_exp(op, a, b);
    launch(op, a, b);
    @(posedge clk); #1;
    chk("hold_hi", 64'(hi), 64'(m_hi));
    chk("hold_lo", 64'(lo), 64'(m_lo));
    wait_idle();
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    reset = 1'b1; start = 1'b0; md_op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // Directed arithmetic cases.
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd3, 32'h0000_1234, 32'd0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0);
    run_op(2'd2, 32'd77, 32'd0);

    // MTHI/MTLO together and individually in IDLE.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mt_both_lo", 64'(lo), 64'hA5A5_A5A5);
    hi_we = 1'b1; wdata = 32'h1111_2222;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1111_2222);
    chk("mthi_lo", 64'(lo), 64'hA5A5_A5A5);
    m_hi = 32'h1111_2222; m_lo = 32'hA5A5_A5A5;

    // MTHI while a divide is busy is ignored.
    push_exp(2'd3, 32'd100, 32'd7);
    launch(2'd3, 32'd100, 32'd7);
    repeat (2) @(posedge clk);
    #1 hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_busy", 64'(hi), 64'(m_hi));
    wait_idle();
    m_hi = 32'd2; m_lo = 32'd14;

    // MTHI in the same cycle as start is dropped.
    hi_we = 1'b1; wdata = 32'h5555_5555;
    push_exp(2'd1, 32'd3, 32'd4);
    launch(2'd1, 32'd3, 32'd4);
    hi_we = 1'b0;
    chk("mthi_start", 64'(hi), 64'(m_hi));
    wait_idle();
    m_hi = 32'd0; m_lo = 32'd12;

    // Flush at busy cycle 10 of a divide, then an immediate new op.
    e.len = 10; e.hi = m_hi; e.lo = m_lo;
    sb_q.push_back(e);
    launch(2'd2, 32'h0012_3456, 32'd9);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'(m_hi));
    chk("flush_lo", 64'(lo), 64'(m_lo));
    run_op(2'd2, 32'd1000, 32'hFFFF_FFFD);

    // Flush together with start prevents the launch.
    flush = 1'b1;
    launch(2'd0, 32'd9, 32'd9);
    flush = 1'b0;
    chk("flush_start", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("flush_start2", 64'(busy), 64'd0);

    // Reset mid-multiply, then an immediate new op.
    launch(2'd1, 32'd5, 32'd6);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_hi", 64'(hi), 64'd0);
    chk("rstmid_lo", 64'(lo), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(2'd1, 32'd5, 32'd6);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b);
    end

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage.
- Owns the HI/LO registers.
- Accepts a one-cycle `start` from EX for MULT/MULTU/DIV/DIVU.
- Drives `busy` back to the hazard/stall logic. Stall logic holds any HI/LO-touching instruction in decode while `busy` or EX-stage `start` is high.
- Also services MTHI/MTLO writes; HI/LO are read out combinationally for MFHI/MFLO.

Parameters:
- MUL_CYCLES, 5, number of cycles `busy` stays high for MULT/MULTU; legal range 1..15.
- DIV_CYCLES, 32, number of radix-2 iteration cycles for DIV/DIVU; fixed at 32 in this version.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- start  input  1  launch operation selected by md_op; sampled on rising edge
- md_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  input  32  rs operand (dividend / multiplicand)
- src_b  input  32  rt operand (divisor / multiplier)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  32  MTHI/MTLO data
- flush  input  1  exception flush: abort in-flight operation
- busy  output  1  operation in progress
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: hi=0, lo=0, busy=0, state IDLE, counter=0, internal accumulators=0. Reset overrides every other input, including reset while BUSY: the operation is dropped and HI/LO are not updated.
- States: IDLE, MUL, DIV.
  - IDLE and start=1: latch operands and op. Go to MUL (op 0x) or DIV (op 1x) and load counter with MUL_CYCLES-1 or DIV_CYCLES-1. busy=1 from the next cycle.
  - MUL: counter decrements each cycle. When counter==0, write the 64-bit product {hi,lo} on that edge and return to IDLE. busy is high exactly MUL_CYCLES cycles.
  - DIV: one restoring shift/subtract step per cycle on magnitudes. When counter==0, write hi=remainder, lo=quotient and return to IDLE. busy is high exactly 32 cycles.
- Result visibility: HI/LO hold their new values in the first cycle where busy=0. HI/LO hold their old values throughout BUSY.
- Signed ops:
  - MULT: 64-bit two's-complement product.
  - DIV: divide magnitudes; quotient sign = a[31]^b[31]; remainder sign = a[31]; quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- Divide by zero, no trap, deterministic result:
  - DIVU: lo=0xFFFFFFFF, hi=src_a.
  - DIV: magnitude rules apply, giving quotient 0xFFFFFFFF before the sign fix-up, then the sign fix-up is applied.
- start while busy: ignored; stall logic guarantees this does not occur.
- hi_we/lo_we:
  - In IDLE with start=0: write HI/LO on the edge.
  - Both asserted: both registers are written.
  - While busy: ignored.
  - In the same cycle as start: start wins and the write is dropped.
- flush: when flush=1, the state goes to IDLE and busy drops on the next edge; HI/LO are unchanged. A flush in the same cycle as start prevents launch.
- hi and lo are driven directly from registers, with no combinational path from inputs.

Test Plan:
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle -> busy high 5 cycles, then hi=0xFFFFFFFE, lo=0x00000001; hi/lo unchanged while busy.
- MULT: a=-3 (0xFFFFFFFD), b=7 -> after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV: a=-7, b=2 -> busy exactly 32 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU by zero: a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV overflow: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI/MTLO:
  - In IDLE with hi_we=lo_we=1, wdata=0xA5A5A5A5 -> both updated next edge.
  - hi_we during DIV busy -> ignored; final hi is the remainder.
  - hi_we in the same cycle as start -> dropped.
- Abort:
  - flush at busy cycle 10 of DIV -> busy=0 next cycle, hi/lo keep pre-op values.
  - reset mid-MUL -> hi=lo=0, busy=0.
  - start issued immediately after the abort -> completes normally.
